board_tracker: RTL

Parametrised successor to the 3x3 position tracker: holds the state of an N x N two-player board, validates each move request against occupancy and turn order, and commits legal moves on a rising edge of move_check. Sits between the player input decoders (one-hot cell enables per player) and the win checker and display logic, which consume the packed board vector. Adds turn tracking, error reporting, a move counter, a full-board lock and an optional one-level-per-move undo history.

---
 rtl/board_pkg.sv | 47 ++++
 rtl/move_history.sv | 36 +++
 rtl/board_tracker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the N x N two-player board tracker: cell codes,
// error and state enumerations, and the one-hot cell decoder.
package board_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    // Largest supported board is 8 x 8.
    localparam int MAX_CELLS = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic [1:0] {
        ERR_BAD_SEL    = 2'b00,
        ERR_OCCUPIED   = 2'b01,
        ERR_WRONG_TURN = 2'b10,
        ERR_LOCKED     = 2'b11
    } err_e;

    typedef enum logic {
        ST_PLAY   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } sel_t;

    // valid is set only when exactly one bit of vec is high.
    function automatic sel_t onehot_to_idx(input logic [MAX_CELLS-1:0] vec);
        sel_t        r;
        int unsigned n;
        r.valid = 1'b0;
        r.idx   = '0;
        n       = 0;
        for (int i = 0; i < MAX_CELLS; i++) begin
            if (vec[i]) begin
                r.idx = MAX_IDX_W'(i);
                n++;
            end
        end
        r.valid = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/move_history.sv
// LIFO of committed cell indices used to roll back moves one at a time.
module move_history #(
    parameter int DEPTH = 9,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [IDX_W-1:0] din,
    output logic [IDX_W-1:0] dout,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top;

    assign top   = ptr - PW'(1);
    assign empty = (ptr == '0);
    assign dout  = empty ? '0 : mem[top[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            ptr <= '0;
        end else if (push) begin
            mem[ptr[IDX_W-1:0]] <= din;
            ptr                 <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= top;
        end
    end

endmodule

// File: rtl/board_tracker.sv
// N x N two-player board state with move validation, turn/error tracking and
// full-board lock. Optional undo history is enabled by BOARD_TRACKER_UNDO_EN.
module board_tracker
    import board_pkg::*;
#(
    parameter int BOARD_DIM = 3,
    parameter int CELLS     = BOARD_DIM * BOARD_DIM,
    parameter int CNT_W     = $clog2(CELLS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_check,
    input  logic [CELLS-1:0]   p1_en,
    input  logic [CELLS-1:0]   p2_en,
    input  logic               new_game,
`ifdef BOARD_TRACKER_UNDO_EN
    input  logic               undo,
`endif
    output logic [2*CELLS-1:0] board,
    output logic               turn,
    output logic               move_ok,
    output logic               move_err,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   move_cnt,
    output logic               full
);
    localparam int IDX_W = $clog2(CELLS);

    logic                   mc_q, req_vld;
    logic [CELLS-1:0]       p1_q, p2_q, on_vec, off_vec;
    logic [CELLS-1:0][1:0]  cells_q, cells_d;
    state_e                 state_q, state_d;
    err_e                   code_q, code_d;
    logic                   turn_d, ok_d, err_d, full_d;
    logic [CNT_W-1:0]       cnt_d;
    sel_t                   sel;
    logic [IDX_W-1:0]       sel_idx;

    assign on_vec  = turn ? p2_q : p1_q;
    assign off_vec = turn ? p1_q : p2_q;
    assign sel     = onehot_to_idx(MAX_CELLS'(on_vec));
    assign sel_idx = sel.idx[IDX_W-1:0];

    generate
        if (IDX_W < MAX_IDX_W) begin : g_sel_hi
            logic unused_sel_hi;
            assign unused_sel_hi = |sel.idx[MAX_IDX_W-1:IDX_W];
        end
    endgenerate

    assign board    = cells_q;
    assign err_code = code_q;

`ifdef BOARD_TRACKER_UNDO_EN
    logic             undo_q, undo_vld, hist_push, hist_pop, hist_empty;
    logic [IDX_W-1:0] hist_top;

    always_ff @(posedge clk) begin
        if (!reset) begin
            undo_q   <= 1'b0;
            undo_vld <= 1'b0;
        end else begin
            undo_q   <= undo;
            undo_vld <= undo & ~undo_q & ~new_game;
        end
    end

    move_history #(.DEPTH(CELLS), .IDX_W(IDX_W)) u_hist (
        .clk   (clk),
        .reset (reset),
        .clear (new_game),
        .push  (hist_push),
        .pop   (hist_pop),
        .din   (sel_idx),
        .dout  (hist_top),
        .empty (hist_empty)
    );
`endif

    always_comb begin
        cells_d = cells_q;
        state_d = state_q;
        turn_d  = turn;
        cnt_d   = move_cnt;
        code_d  = code_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
`ifdef BOARD_TRACKER_UNDO_EN
        hist_push = 1'b0;
        hist_pop  = 1'b0;
`endif
        if (new_game) begin
            cells_d = '0;
            state_d = ST_PLAY;
            turn_d  = 1'b0;
            cnt_d   = '0;
            code_d  = ERR_BAD_SEL;
`ifdef BOARD_TRACKER_UNDO_EN
        end else if (undo_vld) begin
            // Undo outranks a same-cycle move request, which is dropped.
            if (hist_empty) begin
                err_d  = 1'b1;
                code_d = ERR_BAD_SEL;
            end else begin
                cells_d[hist_top] = CELL_EMPTY;
                turn_d   = ~turn;
                cnt_d    = move_cnt - CNT_W'(1);
                state_d  = ST_PLAY;
                ok_d     = 1'b1;
                hist_pop = 1'b1;
            end
`endif
        end else if (req_vld) begin
            if (state_q == ST_LOCKED) begin
                err_d  = 1'b1;
                code_d = ERR_LOCKED;
            end else if (|off_vec) begin
                err_d  = 1'b1;
                code_d = ERR_WRONG_TURN;
            end else if (!sel.valid) begin
                err_d  = 1'b1;
                code_d = ERR_BAD_SEL;
            end else if (cells_q[sel_idx] != CELL_EMPTY) begin
                err_d  = 1'b1;
                code_d = ERR_OCCUPIED;
            end else begin
                cells_d[sel_idx] = turn ? CELL_P2 : CELL_P1;
                turn_d = ~turn;
                cnt_d  = move_cnt + CNT_W'(1);
                ok_d   = 1'b1;
`ifdef BOARD_TRACKER_UNDO_EN
                hist_push = 1'b1;
`endif
                if (cnt_d == CNT_W'(CELLS)) state_d = ST_LOCKED;
            end
        end
        full_d = (cnt_d == CNT_W'(CELLS));
    end

    // Stage 1 captures the move_check edge with its enables; stage 2 commits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mc_q     <= 1'b0;
            req_vld  <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            cells_q  <= '0;
            state_q  <= ST_PLAY;
            turn     <= 1'b0;
            move_ok  <= 1'b0;
            move_err <= 1'b0;
            code_q   <= ERR_BAD_SEL;
            move_cnt <= '0;
            full     <= 1'b0;
        end else begin
            mc_q     <= move_check;
            req_vld  <= move_check & ~mc_q & ~new_game;
            p1_q     <= p1_en;
            p2_q     <= p2_en;
            cells_q  <= cells_d;
            state_q  <= state_d;
            turn     <= turn_d;
            move_ok  <= ok_d;
            move_err <= err_d;
            code_q   <= code_d;
            move_cnt <= cnt_d;
            full     <= full_d;
        end
    end

endmodule
